// File: rtl/inst_fetch_arbiter_pkg.sv
// inst_fetch_arbiter_pkg: shared types and default sizes for the instruction-fetch arbiter
package inst_arb_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
  typedef logic way_t;
endpackage

// File: rtl/inst_fetch_arbiter_if.sv
// inst_fetch_arbiter_if: way0/way1 fetch ports, shared memory port and status of the arbiter
interface inst_fetch_arbiter_if import inst_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              jumpFlag_i;
  logic              way0_request_i;
  logic [ADDR_W-1:0] way0_instAddr_i;
  logic              way0_dataOk_o;
  logic [DATA_W-1:0] way0_inst_o;
  logic              way1_request_i;
  logic [ADDR_W-1:0] way1_instAddr_i;
  logic              way1_dataOk_o;
  logic [DATA_W-1:0] way1_inst_o;
  logic              mem_request_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_dataOk_i;
  logic [DATA_W-1:0] mem_inst_i;
  logic              busy_o;
  logic              timeout_o;
  modport slave (
    input  jumpFlag_i, way0_request_i, way0_instAddr_i, way1_request_i, way1_instAddr_i,
           mem_dataOk_i, mem_inst_i,
    output way0_dataOk_o, way0_inst_o, way1_dataOk_o, way1_inst_o,
           mem_request_o, mem_addr_o, busy_o, timeout_o
  );
  modport master (
    output jumpFlag_i, way0_request_i, way0_instAddr_i, way1_request_i, way1_instAddr_i,
           mem_dataOk_i, mem_inst_i,
    input  way0_dataOk_o, way0_inst_o, way1_dataOk_o, way1_inst_o,
           mem_request_o, mem_addr_o, busy_o, timeout_o
  );
endinterface

// File: rtl/inst_fetch_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie the way other than last wins
module rr_arbiter_2 import inst_arb_pkg::*; (
  input  logic [1:0] req,
  input  way_t       last,
  input  logic [1:0] mask,
  output logic       grant_valid,
  output way_t       grant
);
  logic [1:0] eff;
  always_comb begin
    eff         = req & ~mask;
    grant_valid = |eff;
    grant       = (&eff) ? ~last : eff[1];
  end
endmodule

// File: rtl/inst_fetch_arbiter.sv
// inst_fetch_arbiter: shares one instruction-memory port between two fetch ways
module inst_fetch_arbiter import inst_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic reset_n,
  inst_fetch_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t            state_q;
  way_t              grant_q, last_q, gnt;
  logic              gnt_valid, served, issue, tmo_hit, timeout_q;
  logic [CNT_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] addr_q;
  always_comb begin
    served  = state_q == WAIT && bus.mem_dataOk_i && !bus.jumpFlag_i;
    tmo_hit = tmo_q == CNT_W'(TIMEOUT - 1);
    issue   = gnt_valid && ((state_q == IDLE && !bus.jumpFlag_i) || served);
  end
  // the way just served is masked so a back-to-back issue goes to the other way
  rr_arbiter_2 u_rr (
    .req         ({bus.way1_request_i, bus.way0_request_i}),
    .last        (last_q),
    .mask        (served ? (grant_q ? 2'b10 : 2'b01) : 2'b00),
    .grant_valid (gnt_valid),
    .grant       (gnt)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else if (issue) begin
      state_q <= WAIT;
      grant_q <= gnt;
      last_q  <= gnt;
      addr_q  <= gnt ? bus.way1_instAddr_i : bus.way0_instAddr_i;
      tmo_q   <= '0;
    end else if (state_q != IDLE) begin
      if (bus.mem_dataOk_i) state_q <= IDLE;
      else if (tmo_hit) begin
        state_q   <= IDLE;
        timeout_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 1'b1;
        if (bus.jumpFlag_i) state_q <= FLUSH;
      end
    end
  end
  always_comb begin
    bus.mem_request_o = state_q != IDLE;
    bus.busy_o        = state_q != IDLE;
    bus.mem_addr_o    = addr_q;
    bus.timeout_o     = timeout_q;
    bus.way0_dataOk_o = served && !grant_q;
    bus.way1_dataOk_o = served && grant_q;
    bus.way0_inst_o   = bus.way0_dataOk_o ? bus.mem_inst_i : '0;
    bus.way1_inst_o   = bus.way1_dataOk_o ? bus.mem_inst_i : '0;
  end
endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// tb_inst_fetch_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_inst_fetch_arbiter;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  inst_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  inst_fetch_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  // model: one outstanding fetch (way, killed, cycles waited) plus round-robin history
  bit m_pend, m_way, m_kill, m_last, m_tmo, ms0, ms1;
  int m_age;
  logic [31:0] m_addr;
  logic o_ok0, o_ok1, o_req, o_busy, o_tmo;
  logic [31:0] o_inst0, o_inst1, o_addr;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pend = 0; m_way = 0; m_kill = 0; m_last = 1; m_tmo = 0; m_age = 0; m_addr = '0;
    ms0 = 0; ms1 = 0;
  endtask
  task automatic cyc(input bit j, input bit r0, input logic [31:0] a0, input bit r1,
                     input logic [31:0] a1, input bit ok, input logic [31:0] d);
    bit srv, e0, e1, expire, can, c0, c1, w;
    bus.jumpFlag_i = j; bus.way0_request_i = r0; bus.way0_instAddr_i = a0;
    bus.way1_request_i = r1; bus.way1_instAddr_i = a1; bus.mem_dataOk_i = ok; bus.mem_inst_i = d;
    #1;
    o_ok0 = bus.way0_dataOk_o; o_ok1 = bus.way1_dataOk_o; o_inst0 = bus.way0_inst_o;
    o_inst1 = bus.way1_inst_o; o_req = bus.mem_request_o; o_addr = bus.mem_addr_o;
    o_busy = bus.busy_o; o_tmo = bus.timeout_o;
    srv = m_pend && !m_kill && ok && !j;
    e0 = srv && !m_way;
    e1 = srv && m_way;
    chk("mem_request", o_req, m_pend);
    chk("mem_addr", o_addr, m_addr);
    chk("busy", o_busy, m_pend);
    chk("timeout", o_tmo, m_tmo);
    chk("ok0", o_ok0, e0);
    chk("ok1", o_ok1, e1);
    chk("inst0", o_inst0, e0 ? d : 32'h0);
    chk("inst1", o_inst1, e1 ? d : 32'h0);
    expire = m_pend && !ok && m_age == TMO - 1;
    can = (!m_pend && !j) || srv;
    c0 = r0 && !e0;
    c1 = r1 && !e1;
    if (m_pend) begin
      if (ok) m_pend = 0;
      else if (expire) begin
        m_pend = 0;
        m_tmo = 1;
      end else begin
        m_age++;
        if (j) m_kill = 1;
      end
    end
    if (can && (c0 || c1)) begin
      w = (c0 && c1) ? !m_last : c1;
      m_pend = 1; m_way = w; m_last = w; m_kill = 0; m_age = 0;
      m_addr = w ? a1 : a0;
    end
    ms0 = e0; ms1 = e1;
    @(negedge clk);
  endtask
  initial begin
    bit g0, g1, j;
    logic [31:0] ga0, ga1;
    int cnt;
    bus.jumpFlag_i = 0; bus.way0_request_i = 0; bus.way0_instAddr_i = 0;
    bus.way1_request_i = 0; bus.way1_instAddr_i = 0; bus.mem_dataOk_i = 0; bus.mem_inst_i = 0;
    model_reset();
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_req", o_req, 0);
    reset_n = 1'b1;
    @(negedge clk);
    // both ways requesting continuously: alternating grants, one per cycle
    cyc(0, 1, 32'h100, 1, 32'h200, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 32'h100, 1, 32'h200, 1, 32'hA0 + k);
      chk("alt_ok0", o_ok0, (k % 2) == 0);
      chk("alt_ok1", o_ok1, (k % 2) == 1);
    end
    cyc(0, 0, 0, 0, 0, 1, 32'hB0);
    chk("alt_tail_ok0", o_ok0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // way0 alone, one-cycle memory
    cyc(0, 1, 32'h8000_0000, 0, 0, 0, 0);
    cyc(0, 1, 32'h8000_0000, 0, 0, 0, 0);
    chk("t1_addr", o_addr, 32'h8000_0000);
    chk("t1_req", o_req, 1);
    cyc(0, 1, 32'h8000_0000, 0, 0, 1, 32'h13);
    chk("t1_ok0", o_ok0, 1);
    chk("t1_inst0", o_inst0, 32'h13);
    chk("t1_ok1", o_ok1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // jump during WAIT, late response dropped, re-request served
    cyc(0, 0, 0, 1, 32'h300, 0, 0);
    cyc(1, 0, 0, 1, 32'h300, 0, 0);
    cyc(0, 0, 0, 1, 32'h400, 0, 0);
    chk("flush_busy", o_busy, 1);
    cyc(0, 0, 0, 1, 32'h400, 0, 0);
    cyc(0, 0, 0, 1, 32'h400, 1, 32'hDEAD);
    chk("flush_drop", o_ok1, 0);
    cyc(0, 0, 0, 1, 32'h400, 0, 0);
    chk("flush_idle", o_busy, 0);
    cyc(0, 0, 0, 1, 32'h400, 0, 0);
    chk("reissue_addr", o_addr, 32'h400);
    cyc(0, 0, 0, 1, 32'h400, 1, 32'hABC);
    chk("reissue_ok1", o_ok1, 1);
    chk("reissue_inst1", o_inst1, 32'hABC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // jump and response in the same WAIT cycle
    cyc(0, 1, 32'h500, 0, 0, 0, 0);
    cyc(1, 1, 32'h500, 0, 0, 1, 32'h555);
    chk("jmp_ok_drop", o_ok0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("jmp_ok_idle", o_busy, 0);
    // memory never answers: watchdog
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 32'h600, 0, 0, 0, 0);
      cnt += int'(o_req);
    end
    cyc(0, 0, 0, 1, 32'h700, 0, 0);
    cnt += int'(o_req);
    chk("tmo_cycles", cnt, 4);
    chk("tmo_flag", o_tmo, 1);
    cyc(0, 0, 0, 1, 32'h700, 1, 32'h77);
    chk("tmo_next_ok1", o_ok1, 1);
    chk("tmo_sticky", o_tmo, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // reset in WAIT
    cyc(0, 1, 32'h900, 0, 0, 0, 0);
    cyc(0, 1, 32'h900, 0, 0, 0, 0);
    bus.way0_request_i = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_req", bus.mem_request_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_tmo", bus.timeout_o, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, 32'hBAD);
    chk("stray_ok0", o_ok0, 0);
    // random traffic obeying the request protocol
    g0 = 0; g1 = 0; ga0 = 0; ga1 = 0;
    for (int k = 0; k < 400; k++) begin
      j = ($urandom % 10) == 0;
      if (ms0) g0 = 0;
      else if (!g0 && ($urandom % 2) == 1) begin g0 = 1; ga0 = $urandom & 32'hFFFF_FFFC; end
      if (ms1) g1 = 0;
      else if (!g1 && ($urandom % 2) == 1) begin g1 = 1; ga1 = $urandom & 32'hFFFF_FFFC; end
      if (j) begin ga0 = $urandom & 32'hFFFF_FFFC; ga1 = $urandom & 32'hFFFF_FFFC; end
      cyc(j, g0, ga0, g1, ga1, ($urandom % 5) < 2, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_arbiter.md
# inst_fetch_arbiter

Shares the single instruction-memory port between the way0 and way1 fetch units of the dual-way core. Each way's fetch unit sees the same request / dataOk / address / instruction protocol it would see from a private memory. The arbiter grants one outstanding fetch at a time using round-robin. On a jump it discards an in-flight response, and a timeout watchdog prevents a hung memory from stalling both ways.

## Interface

Parameters:
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction width
- TIMEOUT, 255, maximum cycles an issued fetch may wait for mem_dataOk_i; counter width is clog2(TIMEOUT+1)

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- jumpFlag_i  in  1  redirect; kills the in-flight fetch
- way0_request_i  in  1  level request, held until way0_dataOk_o
- way0_instAddr_i  in  ADDR_W  way0 fetch address, stable while requesting
- way0_dataOk_o  out  1  one-cycle response strobe
- way0_inst_o  out  DATA_W  instruction, valid with way0_dataOk_o
- way1_request_i, way1_instAddr_i, way1_dataOk_o, way1_inst_o  identical to way0
- mem_request_o  out  1  high for the whole outstanding fetch
- mem_addr_o  out  ADDR_W  registered address of the granted way
- mem_dataOk_i  in  1  one-cycle memory response strobe
- mem_inst_i  in  DATA_W  memory data, valid with mem_dataOk_i
- busy_o  out  1  state is not IDLE
- timeout_o  out  1  sticky watchdog error flag

## Operation

- States:
  - IDLE: no fetch outstanding.
  - WAIT: fetch outstanding for grant_q.
  - FLUSH: fetch outstanding, response will be discarded.
- IDLE, jumpFlag_i low, any request: grant by round-robin and go to WAIT.
  - The way not equal to last_q wins; a sole requester always wins.
  - Register mem_addr_o from the winner's address and set grant_q and last_q to the winner.
  - mem_request_o goes high next cycle.
- IDLE with jumpFlag_i high: no grant this cycle.
- WAIT with mem_dataOk_i high and jumpFlag_i low:
  - Assert wayN_dataOk_o for N = grant_q, combinationally in the same cycle.
  - Drive wayN_inst_o = mem_inst_i.
  - Back-to-back issue: in the same cycle, re-arbitrate with the just-served way masked. If the other way is requesting, go directly to WAIT for it; otherwise go to IDLE.
- WAIT with jumpFlag_i high:
  - If mem_dataOk_i is high in the same cycle, drop the data and go to IDLE.
  - Otherwise go to FLUSH.
  - mem_request_o stays high in FLUSH; the memory port cannot cancel a fetch.
- FLUSH:
  - mem_dataOk_i drops the data and goes to IDLE.
  - jumpFlag_i has no further effect.
- The killed way gets no dataOk_o. It re-requests with its new address and is re-arbitrated normally.
- Watchdog:
  - tmo_cnt clears on every issue.
  - It increments each WAIT/FLUSH cycle without mem_dataOk_i.
  - When it reaches TIMEOUT: go to IDLE, deassert mem_request_o, set timeout_o (sticky until reset). The pending way is not served.
- mem_dataOk_i in IDLE is ignored.
- wayN_inst_o is 0 whenever wayN_dataOk_o is low.
- Reset values:
  - State IDLE; last_q = way1, so way0 wins the first tie.
  - mem_request_o = 0, mem_addr_o = 0, tmo_cnt = 0.
  - All dataOk_o = 0, all inst_o = 0, busy_o = 0, timeout_o = 0.
- Reset asserted mid-fetch: everything returns to reset values immediately. A later mem_dataOk_i is ignored.

## Timing

- Request seen in cycle N (IDLE): mem_request_o and mem_addr_o are valid in N+1.
- Response: wayN_dataOk_o is asserted in the same cycle as mem_dataOk_i (zero added latency).
- Earliest round trip: request in N, mem_dataOk_i in N+1, dataOk_o in N+1.
- Back-to-back: with both ways always requesting and 1-cycle memory, one fetch completes per cycle after the first, alternating way0 and way1.
- A fetch that times out has mem_request_o high for exactly TIMEOUT cycles.
- A requester must drop wayN_request_i the cycle after its dataOk_o. The arbiter masks it only in the response cycle.

## Structure

- Package inst_arb_pkg:
  - State enum: IDLE, WAIT, FLUSH.
  - Way index type (1 bit).
  - Default ADDR_W, DATA_W, TIMEOUT constants.
- Sub-module rr_arbiter_2: two request bits plus last-grant and mask inputs; outputs grant_valid and grant index. Purely combinational.
- The FSM, watchdog and response steering live in inst_fetch_arbiter.

## Test plan

- Way0 only, addr 0x8000_0000, memory responds 1 cycle after issue with 0x0000_0013:
  - mem_addr_o = 0x8000_0000 in N+1.
  - way0_dataOk_o and way0_inst_o = 0x13 in N+2.
  - way1_dataOk_o stays 0.
- Both ways request continuously (0x100, 0x200), 1-cycle memory: grants go way0, way1, way0, way1 with no idle cycle between fetches.
- Jump during WAIT, memory answers 3 cycles later:
  - State goes to FLUSH and the response is dropped with no dataOk_o.
  - The way re-requests 0x400 and receives its data normally.
- jumpFlag_i and mem_dataOk_i in the same WAIT cycle: response dropped, state goes to IDLE, no dataOk_o.
- TIMEOUT = 4, memory never answers:
  - mem_request_o is high for exactly 4 cycles, then timeout_o = 1 and stays set.
  - The next request is issued normally.
- reset_n pulsed low in WAIT: all outputs read 0 immediately, and a later stray mem_dataOk_i produces no dataOk_o.
